// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: instruction-cache FSM states and frame layout.
package cpu_types_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    // Widest possible tag (ISETS = 2); narrower tags are stored zero-extended.
    localparam int ICACHE_TAG_W = 29;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking IDLE/FETCH
// miss handler; hits are combinational, misses fetch one word from memory.
module icache
    import cpu_types_pkg::*;
#(
    parameter int ISETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(ISETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t state_q, state_d;
    logic [29:0]   miss_addr_q, miss_addr_d;  // word address {tag, index}
    logic          fill_we;
    icache_frame_t frames_q [ISETS];

    logic [IDX_W-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0] req_tag, miss_tag;
    icache_frame_t    sel_frame;
    logic             hit;
    logic             unused_byte_bits;

    assign req_idx          = imemaddr[2 +: IDX_W];
    assign req_tag          = imemaddr[31:2+IDX_W];
    assign miss_idx         = miss_addr_q[IDX_W-1:0];
    assign miss_tag         = miss_addr_q[29:IDX_W];
    assign unused_byte_bits = ^imemaddr[1:0];

    assign sel_frame = frames_q[req_idx];
    assign hit = (state_q == IDLE) && imemREN && sel_frame.valid
              && (sel_frame.tag == ICACHE_TAG_W'(req_tag));

    assign ihit     = hit;
    assign imemload = hit ? sel_frame.data : 32'h0;
    assign iREN     = (state_q == FETCH);
    assign iaddr    = (state_q == FETCH) ? {miss_addr_q, 2'b00} : 32'h0;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (imemREN && !hit) begin
                    miss_addr_d = imemaddr[31:2];
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                // The fill runs to completion even if the request has gone away.
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // NOTE: only the valid bits are reset; tag and data are don't-care until a fill sets valid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ISETS; i++) begin
                frames_q[i].valid <= 1'b0;
            end
        end else if (fill_we) begin
            frames_q[miss_idx] <= '{valid: 1'b1,
                                    tag:   ICACHE_TAG_W'(miss_tag),
                                    data:  iload};
        end
    end

endmodule
